// File: rtl/dmas_pkg.sv
// Shared constants and FSM encoding for the DMA-side channel streamer.
package dmas_pkg;
    localparam int SAMPLE_W     = 16;
    localparam int DEF_CHANNELS = 128;
    localparam int DEF_CH_BITS  = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;
endpackage

// File: rtl/dmas_stream_bank.sv
// Ping-pong sample store: two banks of CHANNELS samples, synchronous write, registered read.
module dmas_stream_bank
    import dmas_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CH_BITS  = DEF_CH_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_BITS:0]    wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [CH_BITS:0]    rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);
    localparam int DEPTH = 2 * CHANNELS;
    localparam int AW    = $clog2(DEPTH);

    logic [SAMPLE_W-1:0] mem_r [DEPTH];

    // {bank, chan} is packed densely so a non-power-of-two CHANNELS wastes no rows
    function automatic logic [AW-1:0] linear_addr(input logic [CH_BITS:0] a);
        if (a[CH_BITS]) begin
            return AW'(CHANNELS) + AW'(a[CH_BITS-1:0]);
        end else begin
            return AW'(a[CH_BITS-1:0]);
        end
    endfunction

    // Sample write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[linear_addr(wr_addr)] <= wr_data;
        end
    end

    // Registered read port; doubles as the streamer's output data register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= {SAMPLE_W{1'b0}};
        end else if (rd_en) begin
            rd_data <= mem_r[linear_addr(rd_addr)];
        end
    end
endmodule

// File: rtl/dmas_channel_streamer.sv
// Double-buffered per-frame channel sample streamer: fills one bank while the
// other is streamed out channel by channel under valid/ready flow control.
module dmas_channel_streamer
    import dmas_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CH_BITS  = DEF_CH_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [CH_BITS-1:0]         wr_addr,
    input  logic signed [SAMPLE_W-1:0] wr_data,
    input  logic                       wr_commit,
    output logic                       wr_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SAMPLE_W-1:0] out_data,
    output logic [CH_BITS-1:0]         out_chan,
    output logic                       out_first,
    output logic                       out_last,
    output logic                       err
);
    localparam logic [CH_BITS-1:0] CH_COUNT = CH_BITS'(CHANNELS);
    localparam logic [CH_BITS-1:0] LAST_CH  = CH_BITS'(CHANNELS - 1);
    localparam logic [CH_BITS-1:0] CH_ZERO  = {CH_BITS{1'b0}};
    localparam logic [CH_BITS-1:0] CH_ONE   = CH_BITS'(1);

    state_t              state_r, state_n;
    logic [1:0]          full_r, full_n;
    logic                wr_bank_r, rd_bank_r;
    logic [CH_BITS-1:0]  cnt_r, cnt_n;
    logic                out_valid_r, out_first_r, out_last_r, err_r;
    logic [CH_BITS-1:0]  out_chan_r;

    logic                addr_ok_s, wr_ready_s, wr_do_s, commit_do_s, err_set_s;
    logic                advance_s, last_acc_s, issue_s, release_s, rd_sel_bank_s;
    logic [CH_BITS-1:0]  rd_chan_s;
    logic [SAMPLE_W-1:0] rd_data_s;

    assign addr_ok_s   = (wr_addr < CH_COUNT);
    assign wr_ready_s  = ~full_r[wr_bank_r];
    assign wr_do_s     = wr_en & wr_ready_s & addr_ok_s;
    assign commit_do_s = wr_commit & wr_ready_s;
    assign err_set_s   = (wr_en & ~(wr_ready_s & addr_ok_s)) | (wr_commit & ~wr_ready_s);
    assign advance_s   = ~out_valid_r | out_ready;
    assign last_acc_s  = out_valid_r & out_ready & out_last_r;

    // Read sequencing: cnt_r is the next channel to fetch; the other bank is
    // fetched in the release cycle so back-to-back frames have no gap
    always_comb begin
        state_n       = state_r;
        cnt_n         = cnt_r;
        issue_s       = 1'b0;
        release_s     = 1'b0;
        rd_sel_bank_s = rd_bank_r;
        rd_chan_s     = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (full_r[rd_bank_r] & advance_s) begin
                    issue_s   = 1'b1;
                    rd_chan_s = CH_ZERO;
                    cnt_n     = CH_ONE;
                    state_n   = ST_STREAM;
                end else begin
                    cnt_n     = CH_ZERO;
                end
            end
            ST_STREAM: begin
                if (advance_s & (cnt_r < CH_COUNT)) begin
                    issue_s = 1'b1;
                    cnt_n   = cnt_r + CH_ONE;
                end else if (last_acc_s) begin
                    release_s = 1'b1;
                    if (full_r[~rd_bank_r]) begin
                        issue_s       = 1'b1;
                        rd_sel_bank_s = ~rd_bank_r;
                        rd_chan_s     = CH_ZERO;
                        cnt_n         = CH_ONE;
                    end else begin
                        cnt_n   = CH_ZERO;
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_STREAM;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = CH_ZERO;
            end
        endcase
    end

    // Bank occupancy: release and commit always target different banks
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            full_n[b] = (full_r[b] & ~(release_s & (rd_bank_r == 1'(b))))
                      | (commit_do_s & (wr_bank_r == 1'(b)));
        end
    end

    // Control and output-sideband registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            full_r      <= 2'b00;
            wr_bank_r   <= 1'b0;
            rd_bank_r   <= 1'b0;
            cnt_r       <= CH_ZERO;
            out_valid_r <= 1'b0;
            out_chan_r  <= CH_ZERO;
            out_first_r <= 1'b0;
            out_last_r  <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_n;
            full_r      <= full_n;
            wr_bank_r   <= wr_bank_r ^ commit_do_s;
            rd_bank_r   <= rd_bank_r ^ release_s;
            cnt_r       <= cnt_n;
            out_valid_r <= issue_s | (out_valid_r & ~out_ready);
            err_r       <= err_r | err_set_s;
            if (issue_s) begin
                out_chan_r  <= rd_chan_s;
                out_first_r <= (rd_chan_s == CH_ZERO);
                out_last_r  <= (rd_chan_s == LAST_CH);
            end
        end
    end

    dmas_stream_bank #(
        .CHANNELS (CHANNELS),
        .CH_BITS  (CH_BITS)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_do_s),
        .wr_addr ({wr_bank_r, wr_addr}),
        .wr_data (wr_data),
        .rd_en   (issue_s),
        .rd_addr ({rd_sel_bank_s, rd_chan_s}),
        .rd_data (rd_data_s)
    );

    assign wr_ready  = wr_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = rd_data_s;
    assign out_chan  = out_chan_r;
    assign out_first = out_first_r;
    assign out_last  = out_last_r;
    assign err       = err_r;
endmodule

// File: tb/tb_dmas_channel_streamer.sv
// Bench for dmas_channel_streamer: frame-level scoreboard model plus directed
// scenarios with hand-computed literal expectations.
module tb_dmas_channel_streamer;
    localparam int CH = 128;
    localparam int CB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1, wr_en = 1'b0, wr_commit = 1'b0, out_ready = 1'b0;
    logic [CB-1:0]        wr_addr = '0;
    logic signed [15:0]   wr_data = '0;
    logic                 wr_ready, out_valid, out_first, out_last, err;
    logic signed [15:0]   out_data;
    logic [CB-1:0]        out_chan;

    dmas_channel_streamer #(.CHANNELS(CH), .CH_BITS(CB)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_commit(wr_commit), .wr_ready(wr_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
        .out_first(out_first), .out_last(out_last), .err(err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic signed [15:0] data; int chan; } beat_t;
    beat_t              exp_q[$];
    logic signed [15:0] mdl_mem [int];
    logic [1:0]         mdl_full = 2'b00;
    logic               mdl_wb = 1'b0, mdl_rb = 1'b0, mdl_err = 1'b0;
    bit                 live = 1'b0;
    int                 acc_total = 0;
    longint             acc_sum = 0;
    logic signed [15:0] acc_log[$];
    int                 bubble_run = 0;

    always @(posedge clk) begin : model
        beat_t b;
        bit    rdy;
        if (rst) begin
            mdl_full = 2'b00; mdl_wb = 1'b0; mdl_rb = 1'b0; mdl_err = 1'b0;
            exp_q.delete();
            live = 1'b1;
        end else if (live) begin
            rdy = !mdl_full[mdl_wb];
            if (out_valid && out_ready && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                acc_total++;
                acc_sum += b.data;
                acc_log.push_back(b.data);
                if (b.chan == CH - 1) begin
                    mdl_full[mdl_rb] = 1'b0;
                    mdl_rb = ~mdl_rb;
                end
            end
            if (wr_en) begin
                if (rdy && int'(wr_addr) < CH) mdl_mem[int'(mdl_wb) * CH + int'(wr_addr)] = wr_data;
                else mdl_err = 1'b1;
            end
            if (wr_commit) begin
                if (rdy) begin
                    for (int k = 0; k < CH; k++) begin
                        b.data = mdl_mem[int'(mdl_wb) * CH + k];
                        b.chan = k;
                        exp_q.push_back(b);
                    end
                    mdl_full[mdl_wb] = 1'b1;
                    mdl_wb = ~mdl_wb;
                end else begin
                    mdl_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (live && !rst) begin
            chk("wr_ready", wr_ready, !mdl_full[mdl_wb]);
            chk("err", err, mdl_err);
            if (exp_q.size() == 0) begin
                bubble_run = 0;
                chk("out_valid_no_frame", out_valid, 0);
            end else if (out_valid) begin
                bubble_run = 0;
                chk("out_data", out_data, exp_q[0].data);
                chk("out_chan", out_chan, exp_q[0].chan);
                chk("out_first", out_first, exp_q[0].chan == 0);
                chk("out_last", out_last, exp_q[0].chan == CH - 1);
            end else begin
                bubble_run++;
                chk("bubble_ok", (bubble_run <= 1 && exp_q[0].chan == 0), 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [15:0] pat2(input int k);
        if (k == 0) return 16'h8000;
        else if (k == 1) return 16'h7FFF;
        else return 16'(k * 257 - 9000);
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = CB'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        int  base;
        int  n;
        bit  found;
        longint sum0;

        rst = 1'b1; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_chan", out_chan, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_err", err, 0);

        // ramp frame, latency and ordering
        out_ready = 1'b1;
        base = acc_total; sum0 = acc_sum;
        for (int k = 0; k < CH; k++) wr(k, 16'(k - 64));
        commit();
        chk("lat_cycle1_valid", out_valid, 0);
        tick();
        chk("lat_cycle2_valid", out_valid, 1);
        chk("lat_cycle2_data", out_data, -64);
        chk("lat_cycle2_chan", out_chan, 0);
        chk("lat_cycle2_first", out_first, 1);
        drain(400, "t1_drain");
        chk("t1_beats", acc_total - base, 128);
        chk("t1_first_data", acc_log[base], -64);
        chk("t1_last_data", acc_log[base + 127], 63);
        chk("t1_sum", acc_sum - sum0, -64);

        // extremes with out_ready toggling every cycle
        out_ready = 1'b0;
        base = acc_total;
        for (int k = 0; k < CH; k++) wr(k, pat2(k));
        commit();
        n = 0;
        while (exp_q.size() > 0 && n < 800) begin
            out_ready = ~out_ready;
            tick();
            n++;
        end
        chk("t2_drain", exp_q.size(), 0);
        out_ready = 1'b1;
        chk("t2_beats", acc_total - base, 128);
        chk("t2_min", acc_log[base], -32768);
        chk("t2_max", acc_log[base + 1], 32767);
        chk("t2_ch127", acc_log[base + 127], 23639);

        // second bank committed while the first streams; writes while full
        base = acc_total;
        for (int k = 0; k < CH; k++) wr(k, 16'(k * 5 - 300));
        commit();
        for (int k = 0; k < 40; k++) wr(k, 16'(1000 + k));
        commit();
        chk("t3_wr_ready_low", wr_ready, 0);
        wr(5, 16'h1234);
        chk("t3_err_set", err, 1);
        commit();
        chk("t3_err_sticky", err, 1);
        n = 0; found = 1'b0;
        while (!found && n < 400) begin
            if (out_valid && out_ready && out_last) begin
                found = 1'b1;
                tick();
                chk("t3_wr_ready_release", wr_ready, 1);
            end else begin
                tick();
                n++;
            end
        end
        chk("t3_release_seen", found, 1);
        drain(400, "t3_drain");
        chk("t3_beats", acc_total - base, 256);
        chk("t3_b0_ch5_kept", acc_log[base + 5], -275);
        chk("t3_b1_ch0", acc_log[base + 128], 1000);
        chk("t3_b1_ch50_old", acc_log[base + 178], 3850);

        // out-of-range address, then reset mid-frame
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t4_err_cleared", err, 0);
        base = acc_total;
        for (int k = 0; k < CH; k++) wr(k, 16'(k * 37 - 2000));
        wr(200, 16'h5555);
        chk("t4_err_addr", err, 1);
        commit();
        n = 0;
        while (acc_total - base < 50 && n < 200) begin
            tick();
            n++;
        end
        chk("t4_reach50", acc_total - base, 50);
        chk("t4_beat50_chan", out_chan, 50);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t4_rst_out_valid", out_valid, 0);
        chk("t4_rst_wr_ready", wr_ready, 1);
        chk("t4_rst_err", err, 0);
        repeat (10) tick();
        chk("t4_no_more_beats", acc_total - base, 50);
        chk("t4_idle_valid", out_valid, 0);

        // bank memory survives reset: recommit and replay
        commit();
        drain(400, "t4_replay_drain");
        chk("t4_replay_beats", acc_total - base, 178);
        chk("t4_replay_ch10", acc_log[base + 60], -1630);
        chk("t4_replay_ch127", acc_log[base + 177], 2699);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
